// File: rtl/shift_register_piso.sv
// Parallel-in serial-out shift register; captures data_in on load and then streams one bit per clk.
// Latency: first serial bit valid right after the loading edge; bit k valid after the k-th shift edge.
// Backpressure: none; shifts every clock unless reset or load. Optional status outputs: PISO_STATUS_EN.
//
// Parameters:
//   WIDTH     - parallel word width, must be 2 or more.
//   MSB_FIRST - nonzero streams data_in[WIDTH-1] first, zero streams data_in[0] first.
//   FILL_BIT  - value shifted into the vacated end of the register.
//
// With PISO_STATUS_EN defined, the block also exports busy and bits_left so a
// downstream framer can tell when the current word has been fully emitted.
// Without it, no extra ports or counter logic exist.

module shift_register_piso #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1,
  parameter logic        FILL_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             data_out
`ifdef PISO_STATUS_EN
  ,
  output logic                       busy,
  output logic [$clog2(WIDTH+1)-1:0] bits_left
`endif
);

  // The only data state: the word being serialized.
  logic [WIDTH-1:0] shreg;

  // Register contents after one shift, in the configured direction. The
  // output tap sits at the end that leaves the register first, so data_out
  // is a pure flop output with no path from data_in.
  logic [WIDTH-1:0] shifted;

  if (MSB_FIRST != 0) begin : g_msb_first
    assign shifted  = {shreg[WIDTH-2:0], FILL_BIT};
    assign data_out = shreg[WIDTH-1];
  end else begin : g_lsb_first
    assign shifted  = {FILL_BIT, shreg[WIDTH-1:1]};
    assign data_out = shreg[0];
  end

  // Reset clears, load captures (dropping any unsent bits), otherwise shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= data_in;
    end else begin
      shreg <= shifted;
    end
  end

`ifdef PISO_STATUS_EN
  localparam int unsigned CW = $clog2(WIDTH + 1);

  // Remaining unsent bits of the last loaded word.
  logic [CW-1:0] cnt;

  // Reload to WIDTH on load, count down once per shift edge, hold at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(WIDTH);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  // busy rises on the load edge and falls on the WIDTH-th shift edge, which
  // is exactly when the count reaches zero; deriving it keeps the two in step.
  assign busy      = (cnt != '0);
  assign bits_left = cnt;
`endif

endmodule

// File: tb/tb_shift_register_piso.sv
// Bench for shift_register_piso: two instances (MSB-first/fill 0 and LSB-first/fill 1)
// driven with directed and random load/reset patterns, checked against a bit-queue model.
// Status outputs are checked as well when PISO_STATUS_EN is defined.

module tb_shift_register_piso;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic         clk;
  logic         reset;
  logic         load;
  logic [W-1:0] data_in;
  logic         dout_m;
  logic         dout_l;

  int total = 0;
  int bad   = 0;

  // Model: queue of bits still to be emitted, front = current data_out.
  bit q_m[$];
  bit q_l[$];
  int left_m;
  int left_l;

`ifdef PISO_STATUS_EN
  logic          busy_m, busy_l;
  logic [CW-1:0] bl_m, bl_l;
`endif

  shift_register_piso #(.WIDTH(W), .MSB_FIRST(1), .FILL_BIT(1'b0)) u_msb (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .data_in  (data_in),
    .data_out (dout_m)
`ifdef PISO_STATUS_EN
    ,
    .busy      (busy_m),
    .bits_left (bl_m)
`endif
  );

  shift_register_piso #(.WIDTH(W), .MSB_FIRST(0), .FILL_BIT(1'b1)) u_lsb (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .data_in  (data_in),
    .data_out (dout_l)
`ifdef PISO_STATUS_EN
    ,
    .busy      (busy_l),
    .bits_left (bl_l)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit exp_bit(input bit q[$], input bit fill);
    return (q.size() == 0) ? fill : q[0];
  endfunction

  function automatic void mdl_reset();
    q_m.delete();
    q_l.delete();
    for (int i = 0; i < W; i++) begin
      q_m.push_back(1'b0);
      q_l.push_back(1'b0);
    end
    left_m = 0;
    left_l = 0;
  endfunction

  function automatic void mdl_load(input logic [W-1:0] d);
    q_m.delete();
    q_l.delete();
    for (int i = W - 1; i >= 0; i--) q_m.push_back(d[i]);
    for (int i = 0; i < W; i++) q_l.push_back(d[i]);
    left_m = W;
    left_l = W;
  endfunction

  function automatic void mdl_shift();
    if (q_m.size() > 0) void'(q_m.pop_front());
    if (q_l.size() > 0) void'(q_l.pop_front());
    if (left_m > 0) left_m--;
    if (left_l > 0) left_l--;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".msb"}, {31'd0, dout_m}, {31'd0, exp_bit(q_m, 1'b0)});
    check({tag, ".lsb"}, {31'd0, dout_l}, {31'd0, exp_bit(q_l, 1'b1)});
`ifdef PISO_STATUS_EN
    check({tag, ".bl_m"},   32'(bl_m),   32'(left_m));
    check({tag, ".bl_l"},   32'(bl_l),   32'(left_l));
    check({tag, ".busy_m"}, 32'(busy_m), 32'(left_m != 0));
    check({tag, ".busy_l"}, 32'(busy_l), 32'(left_l != 0));
`endif
  endtask

  // Called at a falling edge: apply inputs, let one rising edge act, check at the next falling edge.
  task automatic step(input string tag, input logic ld, input logic [W-1:0] d);
    load    = ld;
    data_in = d;
    @(posedge clk);
    if (ld) mdl_load(d);
    else    mdl_shift();
    @(negedge clk);
    check_all(tag);
  endtask

  // Called at a falling edge: assert reset between edges, hold across one edge, release.
  task automatic do_reset(input string tag);
    load = 1'b0;
    #2;
    reset = 1'b1;
    mdl_reset();
    #1;
    check({tag, ".async_m"}, {31'd0, dout_m}, 32'd0);
    check({tag, ".async_l"}, {31'd0, dout_l}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_all({tag, ".held"});
    reset = 1'b0;
  endtask

  initial begin
    logic [W-1:0] seq;
    reset   = 1'b1;
    load    = 1'b0;
    data_in = '0;
    mdl_reset();

    // Reset held for 20 ns with load low.
    #1;
    check_all("rst_t1");
    @(negedge clk);
    check_all("rst_t10");
    @(negedge clk);
    check_all("rst_t20");
    reset = 1'b0;

    // A5 MSB-first: explicit expected sequence plus model.
    seq = 8'hA5;
    step("a5_load", 1'b1, 8'hA5);
    check("a5_b0", {31'd0, dout_m}, {31'd0, seq[7]});
    for (int k = 1; k < W; k++) begin
      step("a5_sh", 1'b0, W'($urandom));
      check("a5_bk", {31'd0, dout_m}, {31'd0, seq[W-1-k]});
    end
    step("a5_fill", 1'b0, W'($urandom));
    check("a5_fill0", {31'd0, dout_m}, 32'd0);

    // 3C, then fill held beyond WIDTH shifts.
    step("3c_load", 1'b1, 8'h3C);
    for (int k = 0; k < W + 2; k++) step("3c_sh", 1'b0, W'($urandom));

    // FF interrupted by 81 reload mid-stream.
    step("ff_load", 1'b1, 8'hFF);
    for (int k = 0; k < 3; k++) step("ff_sh", 1'b0, 8'h00);
    step("81_load", 1'b1, 8'h81);
    for (int k = 0; k < W; k++) step("81_sh", 1'b0, 8'h00);

    // Load held high for several edges keeps the first bit.
    for (int k = 0; k < 4; k++) step("ld_hold", 1'b1, 8'h5A);

    // Reset mid-stream, then stays 0 with load low (MSB instance fills with 0).
    step("a5b_load", 1'b1, 8'hA5);
    step("a5b_sh", 1'b0, 8'h00);
    step("a5b_sh", 1'b0, 8'h00);
    do_reset("mid_rst");
    for (int k = 0; k < W + 2; k++) begin
      step("post_rst", 1'b0, W'($urandom));
      check("post_rst_m0", {31'd0, dout_m}, 32'd0);
    end

    // Random traffic: sparse loads, occasional asynchronous resets.
    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) do_reset("rnd_rst");
      else       step("rnd", (r < 25), W'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
